// File: rtl/npu_pkg.sv
// Shared types and widths for the neuron-lane MAC sequencer and its requantizer.
package npu_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ACC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4,
    ST_OUT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/mac_requant.sv
// Combinational requantizer: optional ReLU, round-half-up arithmetic shift,
// and saturation of a signed 16-bit accumulator to a signed 8-bit result.
module mac_requant
  import npu_pkg::*;
#(
  parameter int unsigned SHIFT = 7,
  parameter bit          RELU  = 1'b1
) (
  input  logic [ACC_W-1:0] y_i,
  output logic [OP_W-1:0]  q_o
);

  // 17 bits leave headroom for the rounding offset on a full-scale positive value.
  logic signed [ACC_W:0] v;
  logic signed [ACC_W:0] r;

  always_comb begin
    v = {y_i[ACC_W-1], y_i};
    if (RELU && y_i[ACC_W-1]) begin
      v = '0;
    end
  end

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = 17'sd1 <<< (SHIFT - 1);
      assign r = (v + HALF) >>> SHIFT;
    end else begin : g_pass
      assign r = v;
    end
  endgenerate

  always_comb begin
    if (r > 17'sd127) begin
      q_o = 8'h7F;
    end else if (r < -17'sd128) begin
      q_o = 8'h80;
    end else begin
      q_o = r[OP_W-1:0];
    end
  end

endmodule

// File: rtl/mac_seq.sv
// Drives one MAC through a bias-preloaded signed dot product of runtime length,
// then requantizes the accumulator and hands the result out over valid/ready.
module mac_seq
  import npu_pkg::*;
#(
  parameter int unsigned SHIFT = 7,
  parameter bit          RELU  = 1'b1
) (
  input  logic             CLKEXT,
  input  logic             RSTN,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  input  logic [OP_W-1:0]  BIAS,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [OP_W-1:0]  IN_A,
  input  logic [OP_W-1:0]  IN_B,
  output logic             EN_MAC,
  output logic             RST_MAC,
  output logic [OP_W-1:0]  BIAS_OUT,
  output logic [OP_W-1:0]  A_OUT,
  output logic [OP_W-1:0]  B_OUT,
  input  logic [ACC_W-1:0] Y_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OP_W-1:0]  OUT_DATA,
  output logic             BUSY
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rst_q, rst_d;
  logic [OP_W-1:0]  bias_q, bias_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [OP_W-1:0]  out_q, out_d;
  logic [OP_W-1:0]  requant;

  mac_requant #(
    .SHIFT(SHIFT),
    .RELU (RELU)
  ) u_requant (
    .y_i(Y_IN),
    .q_o(requant)
  );

  always_ff @(posedge CLKEXT or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      bias_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      bias_q  <= bias_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

  // MAC enable is registered, so it is raised on the edge that enters LOAD
  // and on every accepted pair, landing in the following cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    rst_d   = 1'b0;
    bias_d  = bias_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          cnt_d   = LEN;
          bias_d  = BIAS;
          en_d    = 1'b1;
          rst_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = (cnt_q != '0) ? ST_ACC : ST_FIN;
      end
      ST_ACC: begin
        if (IN_VALID) begin
          a_d   = IN_A;
          b_d   = IN_B;
          en_d  = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_FIN;
      end
      ST_FIN: begin
        out_d   = requant;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign IN_READY  = (state_q == ST_ACC);
  assign OUT_VALID = (state_q == ST_OUT);
  assign BUSY      = (state_q != ST_IDLE);
  assign EN_MAC    = en_q;
  assign RST_MAC   = rst_q;
  assign BIAS_OUT  = bias_q;
  assign A_OUT     = a_q;
  assign B_OUT     = b_q;
  assign OUT_DATA  = out_q;

endmodule
